tictac_game_ctrl: RTL and testbench

TICTAC_GAME_CTRL -- requirements
Module: tictac_game_ctrl

---
 rtl/tictac_pkg.sv | 44 ++++
 rtl/tictac_game_ctrl_if.sv | 42 ++++
 rtl/tictac_line_detect.sv | 26 ++
 rtl/tictac_game_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tictac_game_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tictac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tictac_pkg
//  Description : Shared types and constants for the tic-tac-toe controller:
//                FSM state encoding, square type, legal square range and the
//                eight winning-line masks (bit n-1 = square n, row-major).
//  Revision    : 1.0 - initial release
// ============================================================================
package tictac_pkg;

  typedef logic [3:0] square_t;

  typedef enum logic [2:0] {
    WAIT_H = 3'd0,
    CHK_H  = 3'd1,
    ENG    = 3'd2,
    CHK_C  = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam square_t SQ_MIN = 4'd1;
  localparam square_t SQ_MAX = 4'd9;

  localparam int NUM_LINES = 8;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals.
  localparam logic [NUM_LINES-1:0][8:0] LINE_MASKS = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  // One-hot occupancy bit for a square; all-zero when the square is out of range.
  function automatic logic [8:0] sq_mask(input square_t sq);
    logic [8:0] m;
    m = '0;
    if (sq >= SQ_MIN && sq <= SQ_MAX) begin
      m = 9'(1) << (sq - SQ_MIN);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tictac_game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tictac_game_ctrl_if
//  Description : Player/engine/result bundle of the tic-tac-toe controller.
//                slave = controller view, master = driver/environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tictac_game_ctrl_if;
  import tictac_pkg::*;

  logic       newGame;
  square_t    hMove;
  logic       hMoveValid;
  logic       engReq;
  square_t    engMove;
  logic       engAck;
  logic       engWin;
  square_t    cMove;
  logic [8:0] humanBoard;
  logic [8:0] compBoard;
  logic       turn;
  logic       hWin;
  logic       cWin;
  logic       draw;
  logic       fault;
  logic       gameOver;
  logic       illegal;

  modport slave (
    input  newGame, hMove, hMoveValid, engMove, engAck, engWin,
    output engReq, cMove, humanBoard, compBoard, turn,
           hWin, cWin, draw, fault, gameOver, illegal
  );

  modport master (
    output newGame, hMove, hMoveValid, engMove, engAck, engWin,
    input  engReq, cMove, humanBoard, compBoard, turn,
           hWin, cWin, draw, fault, gameOver, illegal
  );

endinterface
`default_nettype wire

// File: rtl/tictac_line_detect.sv
`default_nettype none
// ============================================================================
//  Module      : tictac_line_detect
//  Description : Flags whether a 9-square occupancy mask completes any row,
//                column or diagonal.
//  Revision    : 1.0 - initial release
// ============================================================================
module tictac_line_detect
  import tictac_pkg::*;
(
  input  logic [8:0] mask_i,
  output logic       line_o
);

  // A line is present when every square of some line mask is occupied.
  always_comb begin
    line_o = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((mask_i & LINE_MASKS[i]) == LINE_MASKS[i]) begin
        line_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tictac_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tictac_game_ctrl
//  Description : Human-vs-engine tic-tac-toe game controller. Validates human
//                moves, requests and validates engine moves with a timeout,
//                and tracks win/draw/fault results until a new game.
//  Config      : TICTAC_LINE_DETECT_EN - when defined, wins are detected on
//                the board masks; otherwise the engine reports its own win
//                via engWin and humans can only draw.
//  Revision    : 1.0 - initial release
// ============================================================================
module tictac_game_ctrl
  import tictac_pkg::*;
#(
  parameter int ENG_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  tictac_game_ctrl_if.slave bus
);

  localparam int c_TMO_W = (ENG_TIMEOUT < 1) ? 1 : $clog2(ENG_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ENG_TIMEOUT - 1);

  state_t             state_q;
  logic [8:0]         hBoard_q;
  logic [8:0]         cBoard_q;
  square_t            cMove_q;
  logic               turn_q;
  logic               engReq_q;
  logic               hWin_q;
  logic               cWin_q;
  logic               draw_q;
  logic               fault_q;
  logic               gameOver_q;
  logic               illegal_q;
  logic [c_TMO_W-1:0] tmo_q;

  logic [8:0] w_occ;
  logic [8:0] w_hBit;
  logic [8:0] w_eBit;
  logic       w_hOk;
  logic       w_eOk;
  logic       w_full;
  logic       w_hLine;
  logic       w_cLine;

  assign w_occ  = hBoard_q | cBoard_q;
  assign w_hBit = sq_mask(bus.hMove);
  assign w_eBit = sq_mask(bus.engMove);
  // Out-of-range squares map to an empty mask, so a zero mask means illegal.
  assign w_hOk  = (w_hBit != '0) && ((w_hBit & w_occ) == '0);
  assign w_eOk  = (w_eBit != '0) && ((w_eBit & w_occ) == '0);
  assign w_full = (w_occ == 9'h1FF);

`ifdef TICTAC_LINE_DETECT_EN
  tictac_line_detect u_h_line (.mask_i(hBoard_q), .line_o(w_hLine));
  tictac_line_detect u_c_line (.mask_i(cBoard_q), .line_o(w_cLine));
`else
  // Engine's own win claim, captured with its accepted move.
  logic engWin_q;
  assign w_hLine = 1'b0;
  assign w_cLine = engWin_q;
`endif

  // Game FSM with registered outputs; newGame overrides every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_H;
      hBoard_q   <= '0;
      cBoard_q   <= '0;
      cMove_q    <= '0;
      turn_q     <= 1'b1;
      engReq_q   <= 1'b0;
      hWin_q     <= 1'b0;
      cWin_q     <= 1'b0;
      draw_q     <= 1'b0;
      fault_q    <= 1'b0;
      gameOver_q <= 1'b0;
      illegal_q  <= 1'b0;
      tmo_q      <= '0;
`ifndef TICTAC_LINE_DETECT_EN
      engWin_q   <= 1'b0;
`endif
    end else begin
      illegal_q <= 1'b0;
      if (bus.newGame) begin
        state_q    <= WAIT_H;
        hBoard_q   <= '0;
        cBoard_q   <= '0;
        cMove_q    <= '0;
        turn_q     <= 1'b1;
        engReq_q   <= 1'b0;
        hWin_q     <= 1'b0;
        cWin_q     <= 1'b0;
        draw_q     <= 1'b0;
        fault_q    <= 1'b0;
        gameOver_q <= 1'b0;
        tmo_q      <= '0;
`ifndef TICTAC_LINE_DETECT_EN
        engWin_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          WAIT_H: begin
            if (bus.hMoveValid) begin
              if (w_hOk) begin
                hBoard_q <= hBoard_q | w_hBit;
                turn_q   <= 1'b0;
                state_q  <= CHK_H;
              end else begin
                illegal_q <= 1'b1;
              end
            end
          end
          CHK_H: begin
            if (w_hLine) begin
              hWin_q     <= 1'b1;
              gameOver_q <= 1'b1;
              state_q    <= OVER;
            end else if (w_full) begin
              draw_q     <= 1'b1;
              gameOver_q <= 1'b1;
              state_q    <= OVER;
            end else begin
              engReq_q <= 1'b1;
              tmo_q    <= '0;
              state_q  <= ENG;
            end
          end
          ENG: begin
            if (bus.engAck) begin
              engReq_q <= 1'b0;
              if (w_eOk) begin
                cBoard_q <= cBoard_q | w_eBit;
                cMove_q  <= bus.engMove;
`ifndef TICTAC_LINE_DETECT_EN
                engWin_q <= bus.engWin;
`endif
                state_q  <= CHK_C;
              end else begin
                fault_q    <= 1'b1;
                gameOver_q <= 1'b1;
                state_q    <= OVER;
              end
            end else if (tmo_q >= c_TMO_LAST) begin
              engReq_q   <= 1'b0;
              fault_q    <= 1'b1;
              gameOver_q <= 1'b1;
              state_q    <= OVER;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          CHK_C: begin
            if (w_cLine) begin
              cWin_q     <= 1'b1;
              gameOver_q <= 1'b1;
              state_q    <= OVER;
            end else if (w_full) begin
              draw_q     <= 1'b1;
              gameOver_q <= 1'b1;
              state_q    <= OVER;
            end else begin
              turn_q  <= 1'b1;
              state_q <= WAIT_H;
            end
          end
          OVER: begin
            state_q <= OVER;
          end
          default: begin
            state_q <= WAIT_H;
            turn_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.engReq     = engReq_q;
  assign bus.cMove      = cMove_q;
  assign bus.humanBoard = hBoard_q;
  assign bus.compBoard  = cBoard_q;
  assign bus.turn       = turn_q;
  assign bus.hWin       = hWin_q;
  assign bus.cWin       = cWin_q;
  assign bus.draw       = draw_q;
  assign bus.fault      = fault_q;
  assign bus.gameOver   = gameOver_q;
  assign bus.illegal    = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_tictac_game_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tictac_game_ctrl
//  Description : Scoreboard bench for tictac_game_ctrl. A game-rule model
//                predicts every change of the visible outputs; a monitor pops
//                and compares each time the outputs change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tictac_game_ctrl;

  localparam int ENG_TIMEOUT = 15;
`ifdef TICTAC_LINE_DETECT_EN
  localparam bit LINE_EN = 1'b1;
`else
  localparam bit LINE_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tictac_game_ctrl_if bus ();

  tictac_game_ctrl #(.ENG_TIMEOUT(ENG_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [8:0] hb;
    logic [8:0] cb;
    logic [3:0] cm;
    logic       turn;
    logic       engReq;
    logic       hWin;
    logic       cWin;
    logic       draw;
    logic       fault;
    logic       gameOver;
    logic       illegal;
  } snap_t;

  int LN [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                    '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  snap_t exp_q[$];
  snap_t cur;
  snap_t mon_prev;
  bit    mon_en = 1'b0;
  int    tests = 0;
  int    fails = 0;

  function automatic snap_t sample();
    snap_t s;
    s.hb = bus.humanBoard;  s.cb = bus.compBoard;  s.cm = bus.cMove;
    s.turn = bus.turn;      s.engReq = bus.engReq; s.hWin = bus.hWin;
    s.cWin = bus.cWin;      s.draw = bus.draw;     s.fault = bus.fault;
    s.gameOver = bus.gameOver; s.illegal = bus.illegal;
    return s;
  endfunction

  function automatic snap_t reset_snap();
    snap_t s;
    s = '0;
    s.turn = 1'b1;
    return s;
  endfunction

  function automatic bit has_line(input logic [8:0] m);
    for (int i = 0; i < 8; i++)
      if (m[LN[i][0]-1] && m[LN[i][1]-1] && m[LN[i][2]-1]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_empty(input int sq);
    if (sq < 1 || sq > 9) return 1'b0;
    return !cur.hb[sq-1] && !cur.cb[sq-1];
  endfunction

  function automatic int pick_empty();
    int e[$];
    for (int i = 1; i <= 9; i++) if (is_empty(i)) e.push_back(i);
    if (e.size() == 0) return 1;
    return e[$urandom_range(0, e.size() - 1)];
  endfunction

  function automatic int pick_taken();
    int e[$];
    for (int i = 1; i <= 9; i++) if (!is_empty(i)) e.push_back(i);
    if (e.size() == 0) return 0;
    return e[$urandom_range(0, e.size() - 1)];
  endfunction

  // Record an expected output change only when the model state actually moves.
  task automatic push(input snap_t s);
    if (s !== cur) begin
      exp_q.push_back(s);
      cur = s;
    end
  endtask

  // Monitor: every visible change of the outputs is one DUT presentation.
  always @(negedge clock) begin
    snap_t s;
    snap_t e;
    s = sample();
    if (mon_en && (s !== mon_prev)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %h, required unchanged %h", s, mon_prev);
      end else begin
        e = exp_q.pop_front();
        if (s !== e) begin
          fails++;
          $display("FAIL snapshot: got %h, required %h", s, e);
        end
      end
    end
    mon_prev = s;
  end

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d predicted changes still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic human_move(input int sq);
    snap_t s;
    bit    track;
    track = cur.turn;
    if (track) begin
      s = cur;
      if (is_empty(sq)) begin
        s.hb[sq-1] = 1'b1;
        s.turn     = 1'b0;
        push(s);
        if (LINE_EN && has_line(s.hb)) begin
          s.hWin = 1'b1; s.gameOver = 1'b1;
        end else if ((s.hb | s.cb) == 9'h1FF) begin
          s.draw = 1'b1; s.gameOver = 1'b1;
        end else begin
          s.engReq = 1'b1;
        end
        push(s);
      end else begin
        s.illegal = 1'b1;
        push(s);
        s.illegal = 1'b0;
        push(s);
      end
    end
    @(posedge clock); #1;
    bus.hMove = 4'(sq); bus.hMoveValid = 1'b1;
    @(posedge clock); #1;
    bus.hMoveValid = 1'b0;
    if (track) drain("human", 10);
    else idle(3);
  endtask

  task automatic engine(input int sq, input bit win, input int delay);
    snap_t s;
    bit    track;
    bit    cw;
    track = cur.engReq;
    if (track) begin
      s = cur;
      if (is_empty(sq)) begin
        s.cb[sq-1] = 1'b1;
        s.cm       = 4'(sq);
        s.engReq   = 1'b0;
        push(s);
        cw = LINE_EN ? has_line(s.cb) : win;
        if (cw) begin
          s.cWin = 1'b1; s.gameOver = 1'b1;
        end else if ((s.hb | s.cb) == 9'h1FF) begin
          s.draw = 1'b1; s.gameOver = 1'b1;
        end else begin
          s.turn = 1'b1;
        end
        push(s);
      end else begin
        s.fault = 1'b1; s.gameOver = 1'b1; s.engReq = 1'b0;
        push(s);
      end
    end
    repeat (delay) @(posedge clock);
    @(posedge clock); #1;
    bus.engMove = 4'(sq); bus.engAck = 1'b1; bus.engWin = win;
    @(posedge clock); #1;
    bus.engAck = 1'b0; bus.engWin = 1'b0;
    if (track) drain("engine", 10);
    else idle(3);
  endtask

  // Engine never answers: fault after exactly ENG_TIMEOUT cycles of engReq.
  task automatic engine_silent();
    snap_t s;
    int    cnt;
    int    n;
    s = cur;
    s.fault = 1'b1; s.gameOver = 1'b1; s.engReq = 1'b0;
    push(s);
    cnt = 1;
    n = 0;
    while (n < 40) begin
      @(negedge clock); #1;
      n++;
      if (bus.engReq) cnt++;
      else break;
    end
    tests++;
    if (cnt != ENG_TIMEOUT) begin
      fails++;
      $display("FAIL timeout_length: engReq high %0d cycles, required %0d", cnt, ENG_TIMEOUT);
    end
    drain("silent", 5);
  endtask

  task automatic newgame(input bit with_strobes);
    int hs;
    int es;
    hs = pick_empty();
    es = pick_empty();
    push(reset_snap());
    @(posedge clock); #1;
    bus.newGame = 1'b1;
    if (with_strobes) begin
      bus.hMove = 4'(hs); bus.hMoveValid = 1'b1;
      bus.engMove = 4'(es); bus.engAck = 1'b1;
    end
    @(posedge clock); #1;
    bus.newGame = 1'b0; bus.hMoveValid = 1'b0; bus.engAck = 1'b0;
    drain("newgame", 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hseq[5];
    int eseq[4];
    int sq;
    int r;
    bus.newGame = 1'b0; bus.hMove = '0; bus.hMoveValid = 1'b0;
    bus.engMove = '0; bus.engAck = 1'b0; bus.engWin = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock); #1;
    tests++;
    if (sample() !== reset_snap()) begin
      fails++;
      $display("FAIL reset_state: got %h, required %h", sample(), reset_snap());
    end
    cur = reset_snap();
    mon_prev = sample();
    mon_en = 1'b1;

    // Human centre, engine corner after a short wait.
    human_move(5);
    engine(1, 1'b0, 2);

    // Rejected human moves: occupied, zero, out of range, engine-owned.
    human_move(5);
    human_move(0);
    human_move(12);
    human_move(1);

    // Human strobe during ENG is ignored; newGame beats simultaneous strobes.
    human_move(9);
    human_move(3);
    newgame(1'b1);

    // Human row 1,2,3 against engine 5,9.
    human_move(1);
    engine(5, 1'b0, 0);
    human_move(2);
    engine(9, 1'b0, 1);
    human_move(3);
    idle(5);
    newgame(1'b0);

    // Engine timeout, then a move into a dead game, then engine square 0.
    human_move(1);
    engine_silent();
    human_move(2);
    newgame(1'b0);
    human_move(1);
    engine(0, 1'b0, 0);
    newgame(1'b0);

    // Full-board draw with no line for either side.
    hseq = '{1, 3, 4, 8, 9};
    eseq = '{2, 5, 6, 7};
    for (int i = 0; i < 5; i++) begin
      human_move(hseq[i]);
      if (i < 4) engine(eseq[i], 1'b0, i);
    end
    newgame(1'b0);

    // Reset in the middle of an engine request.
    human_move(4);
    push(reset_snap());
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.engReq !== 1'b0 || sample() !== reset_snap()) begin
      fails++;
      $display("FAIL reset_mid_eng: got %h, required %h", sample(), reset_snap());
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    drain("reset", 4);
    @(posedge clock); #1;
    bus.engMove = 4'd1; bus.engAck = 1'b1;
    @(posedge clock); #1;
    bus.engAck = 1'b0;
    idle(4);

    // Randomised games against the rule model.
    for (int g = 0; g < 30; g++) begin
      newgame($urandom_range(0, 3) == 0);
      for (int step = 0; step < 24 && !cur.gameOver; step++) begin
        if (cur.turn) begin
          r = $urandom_range(0, 9);
          sq = (r < 7) ? pick_empty() : $urandom_range(0, 15);
          human_move(sq);
        end else if (cur.engReq) begin
          r = $urandom_range(0, 19);
          if (r == 0) begin
            engine_silent();
          end else if (r == 1) begin
            engine($urandom_range(0, 1) ? 0 : $urandom_range(10, 15), 1'b0, 0);
          end else if (r == 2) begin
            engine(pick_taken(), 1'b0, 1);
          end else begin
            if (r == 3) human_move(pick_empty());
            engine(pick_empty(), $urandom_range(0, 7) == 0, $urandom_range(0, 8));
          end
        end else begin
          break;
        end
        if ($urandom_range(0, 29) == 0) break;
      end
    end
    newgame(1'b0);
    drain("final", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
